io_bus_fabric: RTL and testbench
================================

// Module: io_bus_fabric
// PURPOSE
//  Parametrised I/O-space decoder and response fabric for the CPU data bus
//  (d_io cycles). Replaces per-design hand-written casez decode and OR-ed acks.
//  Registers a one-hot peripheral select from a base/mask table and muxes the
//  selected peripheral's read data. Answers unmapped ports and hung peripherals
//  itself, and latches error information for debug.
// PARAMETERS
//  NUM_PORTS   8                      number of peripheral slots, 1..16
//  ADDR_WIDTH  16                     I/O address width; bus carries [ADDR_WIDTH-1:1]
//  DATA_WIDTH  16                     data width
//  TIMEOUT     64                     BUSY cycles without ack before fabric answers, >=2
//  PORT_BASE   {NUM_PORTS{16'h0}}     packed ADDR_WIDTH-bit base per slot, slot 0 in LSBs
//  PORT_MASK   {NUM_PORTS{16'hffff}}  packed compare masks; 1 = bit compared
// PORTS
//  clk            in   1                      system clock
//  reset          in   1                      asynchronous, active-high
//  data_m_access  in   1                      host I/O request; held high until data_m_ack
//  data_m_addr    in   ADDR_WIDTH-1           host word address [ADDR_WIDTH-1:1]
//  data_m_wr_en   in   1                      host write
//  data_m_data_in out  DATA_WIDTH             read data to host; valid while data_m_ack
//  data_m_ack     out  1                      one-cycle completion pulse
//  cs             out  NUM_PORTS              registered one-hot peripheral select
//  periph_ack     in   NUM_PORTS              per-slot ack
//  periph_data    in   NUM_PORTS*DATA_WIDTH   per-slot read data, slot 0 in LSBs
//  err_clr        in   1                      clears sticky error state
//  err_timeout    out  1                      sticky: a timeout has occurred
//  err_addr       out  ADDR_WIDTH-1           address of the last timed-out access
//  err_wr         out  1                      wr_en of the last timed-out access
//  err_count      out  8                      saturating timeout count
// BEHAVIOUR
//  Reset: FSM=IDLE; cs=0; data_m_ack=0; data_m_data_in=0; err_* outputs=0;
//    timeout counter=0. Reset mid-transaction aborts it with no ack.
//  Decode: {data_m_addr,1'b0} & MASK[i] == BASE[i] & MASK[i].
//    Lowest matching index wins.
//  FSM IDLE, BUSY, ACK. Cycle 0 is the first cycle with access high in IDLE.
//  - IDLE, access, match i: cs<=onehot(i), counter<=0, ->BUSY; cs high from cycle 1.
//  - IDLE, access, no match: ->ACK; ack in cycle 1, data 0.
//  - BUSY: counter++ each cycle. periph_ack from non-selected slots is ignored.
//  - BUSY, periph_ack[sel] in cycle k: latch periph_data[sel]; cs<=0; ->ACK.
//    Ack in cycle k+1.
//  - BUSY, counter==TIMEOUT-1, no ack: data<= all ones; cs<=0; err_timeout<=1;
//    err_addr/err_wr latched; err_count++ (saturates at 255); ->ACK.
//    Ack in cycle TIMEOUT+1.
//  - Ack and timeout in the same cycle: the ack wins; no error is recorded.
//  - BUSY, access dropped before ack (host abort): cs<=0; ->IDLE; no ack, no error.
//  - ACK: data_m_ack=1 for exactly this cycle; ->IDLE unconditionally.
//    Host deasserts access in the cycle after the ack.
//  data_m_data_in holds its last value outside ACK; data_m_ack=0 outside ACK.
//  cs is never multi-hot. Exactly one ack is issued per accepted request.
//  periph_ack in IDLE/ACK is ignored.
//  err_clr zeroes err_timeout and err_count. If it coincides with a timeout,
//    the new error wins: err_timeout=1, err_count=1.
//  The block does not route write data; peripherals take host write data directly.
// TESTING
//  1 Slot 2 BASE=16'hfffa MASK=16'hfffe; read 0xfffa, periph acks the cycle
//    after cs with 16'h1234 -> cs=8'b0000_0100 for cycles 1-2, ack cycle 3,
//    data 16'h1234.
//  2 Unmapped 0x0080 read -> cs stays 0; ack cycle 1; data 16'h0000;
//    err_timeout=0.
//  3 Mapped slot never acks, TIMEOUT=64 -> ack cycle 65, data 16'hffff,
//    err_timeout=1, err_addr=addr, err_count=1; repeat x300 -> err_count=255.
//  4 Slots 1 and 5 overlap on 0xfff0; slot 5 also asserts ack -> cs=slot 1 only;
//    slot 5 ack ignored; data is slot 1's.
//  5 Ack at counter==TIMEOUT-1 -> real data returned, no error;
//    err_clr with coincident timeout -> err_count=1.
//  6 Async reset asserted in BUSY -> cs, ack and err outputs drop to 0 at once;
//    no ack after release; next access decodes normally.

Source files
------------

// File: rtl/io_bus_if.sv
// ---------------------------------------------------------------------------
// io_bus_if
//   Host side of the CPU I/O data bus (d_io cycles) as seen by the I/O fabric.
//   master : the CPU, drives the request and receives data/ack.
//   slave  : the fabric, answers the request.
// Signals
//   data_m_access   host I/O request, held high until data_m_ack
//   data_m_addr     host word address [ADDR_WIDTH-1:1]
//   data_m_wr_en    host write
//   data_m_data_in  read data to host, valid while data_m_ack
//   data_m_ack      one-cycle completion pulse
// ---------------------------------------------------------------------------
interface io_bus_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  data_m_access;
    logic [ADDR_WIDTH-1:1] data_m_addr;
    logic                  data_m_wr_en;
    logic [DATA_WIDTH-1:0] data_m_data_in;
    logic                  data_m_ack;

    modport master (
        output data_m_access, data_m_addr, data_m_wr_en,
        input  data_m_data_in, data_m_ack
    );

    modport slave (
        input  data_m_access, data_m_addr, data_m_wr_en,
        output data_m_data_in, data_m_ack
    );
endinterface

// File: rtl/io_bus_fabric.sv
// ---------------------------------------------------------------------------
// io_bus_fabric
//   I/O-space decoder and response fabric for the CPU data bus. Decodes the
//   host address against a base/mask table into a registered one-hot chip
//   select, returns the selected peripheral's read data, answers unmapped
//   ports (data 0) and hung peripherals (data all ones) itself, and keeps
//   sticky error information about timed-out accesses.
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   host         io_bus_if.slave: access/addr/wr_en in, data_in/ack out
//   cs           registered one-hot peripheral select
//   periph_ack   per-slot acknowledge
//   periph_data  per-slot read data, slot 0 in LSBs
//   err_clr      clears err_timeout and err_count
//   err_timeout  sticky: a timeout has occurred
//   err_addr     address of the last timed-out access
//   err_wr       wr_en of the last timed-out access
//   err_count    saturating timeout count
// ---------------------------------------------------------------------------
module io_bus_fabric #(
    parameter int NUM_PORTS  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64,
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_BASE = '0,
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_MASK = '1
) (
    input  logic                            clk,
    input  logic                            reset,
    io_bus_if.slave                         host,
    output logic [NUM_PORTS-1:0]            cs,
    input  logic [NUM_PORTS-1:0]            periph_ack,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] periph_data,
    input  logic                            err_clr,
    output logic                            err_timeout,
    output logic [ADDR_WIDTH-1:1]           err_addr,
    output logic                            err_wr,
    output logic [7:0]                      err_count
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                state, state_next;
    logic [IDX_W-1:0]      sel_idx;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [NUM_PORTS-1:0]  hit_onehot;
    logic [ADDR_WIDTH-1:0] addr_full;
    logic [DATA_WIDTH-1:0] periph_word [NUM_PORTS];

    // FSM strobes consumed by the datapath register block.
    logic accept, miss, take_ack, take_timeout, abort;

    assign addr_full = {host.data_m_addr, 1'b0};

    // Address decode. Scanning from the top slot down lets the lowest
    // matching slot overwrite any higher one, so priority falls out naturally.
    // NOTE: every signal written here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if ((addr_full & PORT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (PORT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & PORT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit           = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            periph_word[i] = periph_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A host abort outranks a late ack (the host has gone),
    // and a peripheral ack outranks a timeout in the same cycle.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        miss         = 1'b0;
        take_ack     = 1'b0;
        take_timeout = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (host.data_m_access) begin
                    if (hit) begin
                        accept     = 1'b1;
                        state_next = BUSY;
                    end else begin
                        miss       = 1'b1;
                        state_next = ACK;
                    end
                end
            end
            BUSY: begin
                if (!host.data_m_access) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (periph_ack[sel_idx]) begin
                    take_ack   = 1'b1;
                    state_next = ACK;
                end else if (count == CNT_LAST) begin
                    take_timeout = 1'b1;
                    state_next   = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and error registers.
    // NOTE: every register here is reset, so an abort by reset leaves no
    // stale select, data or error state behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs          <= '0;
            sel_idx     <= '0;
            count       <= '0;
            rd_data     <= '0;
            err_timeout <= 1'b0;
            err_addr    <= '0;
            err_wr      <= 1'b0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                cs      <= hit_onehot;
                sel_idx <= hit_idx;
            end else if (abort || take_ack || take_timeout) begin
                cs <= '0;
            end

            if (accept) begin
                count <= '0;
            end else if (state == BUSY) begin
                count <= count + CNT_W'(1);
            end

            if (miss) begin
                rd_data <= '0;
            end else if (take_ack) begin
                rd_data <= periph_word[sel_idx];
            end else if (take_timeout) begin
                rd_data <= '1;
            end

            // A timeout coinciding with err_clr counts as the first new error.
            if (take_timeout) begin
                err_timeout <= 1'b1;
                err_addr    <= host.data_m_addr;
                err_wr      <= host.data_m_wr_en;
                if (err_clr) begin
                    err_count <= 8'd1;
                end else if (err_count != 8'hff) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (err_clr) begin
                err_timeout <= 1'b0;
                err_count   <= '0;
            end
        end
    end

    assign host.data_m_ack     = (state == ACK);
    assign host.data_m_data_in = rd_data;

endmodule

// File: tb/tb_io_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_io_bus_fabric
//   Scoreboard bench for io_bus_fabric. A driver issues host accesses and
//   pushes the expected response (data, ack latency, select, error state)
//   computed from a table-driven reference model; a peripheral model acks
//   after a programmed delay once its select is seen; a monitor pops and
//   compares whenever the fabric acks, and checks cs every cycle.
// ---------------------------------------------------------------------------
module tb_io_bus_fabric;
    localparam int NP    = 8;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int TO    = 64;
    localparam int NEVER = 100000;

    // Slot 7 .. slot 0.
    localparam logic [NP*AW-1:0] BASE_P = {16'h0000, 16'h4000, 16'hfff0, 16'h3000,
                                           16'h2000, 16'hfffa, 16'hfff0, 16'h0100};
    localparam logic [NP*AW-1:0] MASK_P = {16'hffff, 16'hc000, 16'hfff0, 16'hfff0,
                                           16'hf000, 16'hfffe, 16'hfffe, 16'hff00};

    typedef struct {
        bit          mapped;
        int          slot;
        int          start;
        int          lat;
        logic [15:0] data;
        logic        et;
        logic [14:0] ea;
        logic        ew;
        logic [7:0]  ec;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP-1:0]    cs;
    logic [NP-1:0]    periph_ack;
    logic [NP-1:0]    model_ack = '0;
    logic [NP-1:0]    rogue_mask = '0;
    logic [NP*DW-1:0] periph_data;
    logic             err_clr = 1'b0;
    logic             err_timeout;
    logic [AW-1:1]    err_addr;
    logic             err_wr;
    logic [7:0]       err_count;

    logic [15:0] resp_data  [NP];
    int          resp_delay [NP];
    int          cs_age     [NP];

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   cs_free = 1'b0;

    // Reference error state.
    logic        m_et = 1'b0;
    logic [14:0] m_ea = '0;
    logic        m_ew = 1'b0;
    int          m_ec = 0;

    io_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    io_bus_fabric #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO),
        .PORT_BASE (BASE_P),
        .PORT_MASK (MASK_P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (bus),
        .cs         (cs),
        .periph_ack (periph_ack),
        .periph_data(periph_data),
        .err_clr    (err_clr),
        .err_timeout(err_timeout),
        .err_addr   (err_addr),
        .err_wr     (err_wr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NP; g++) begin : g_pdata
        assign periph_data[g*DW +: DW] = resp_data[g];
    end
    assign periph_ack = model_ack | rogue_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lowest slot whose compared bits equal its base; -1 when unmapped.
    function automatic int ref_decode(input logic [14:0] a);
        logic [15:0] full;
        full = {a, 1'b0};
        for (int i = 0; i < NP; i++) begin
            if ((full & MASK_P[i*AW +: AW]) == (BASE_P[i*AW +: AW] & MASK_P[i*AW +: AW]))
                return i;
        end
        return -1;
    endfunction

    // Peripheral model: a selected slot acks when it has seen its select for
    // resp_delay cycles (delay 0 = ack in the first select cycle).
    initial begin
        for (int i = 0; i < NP; i++) begin
            cs_age[i]     = 0;
            resp_delay[i] = NEVER;
            resp_data[i]  = '0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NP; i++) begin
                if (cs[i] === 1'b1) begin
                    model_ack[i] = (cs_age[i] == resp_delay[i]);
                    cs_age[i]++;
                end else begin
                    model_ack[i] = 1'b0;
                    cs_age[i]    = 0;
                end
            end
        end
    end

    // Monitor: select checked every cycle, responses popped on each ack.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            logic [NP-1:0] exp_cs;
            exp_t e;
            int rel;
            if (!$onehot0(cs)) begin
                vectors++;
                miscompares++;
                $display("FAIL cs_onehot: got %b, expected at most one bit", cs);
            end
            exp_cs = '0;
            if (sb.size() > 0) begin
                rel = cyc - sb[0].start;
                if (sb[0].mapped && rel >= 1 && rel < sb[0].lat)
                    exp_cs = NP'(1) << sb[0].slot;
            end
            if (!cs_free) check("cs", cs, exp_cs);
            if (bus.data_m_ack === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ack: got ack, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_latency", cyc - e.start, e.lat);
                    check("rd_data", bus.data_m_data_in, e.data);
                    check("err_timeout", err_timeout, e.et);
                    check("err_count", err_count, e.ec);
                    if (e.et) begin
                        check("err_addr", err_addr, e.ea);
                        check("err_wr", err_wr, e.ew);
                    end
                end
            end
        end
    end

    // One host access. pdata < 0 means random read data; clr_at is the
    // cycle (relative to cycle 0) in which err_clr is pulsed, -1 for none.
    task automatic run_txn(input logic [14:0] addr, input logic wr, input int delay,
                           input logic [NP-1:0] rogue, input int clr_at, input int pdata);
        exp_t e;
        int   slot;
        bit   got;
        bit   timed_out;
        slot = ref_decode(addr);
        for (int i = 0; i < NP; i++) begin
            resp_data[i]  = 16'($urandom);
            resp_delay[i] = NEVER;
        end
        e.mapped = (slot >= 0);
        e.slot   = slot;
        timed_out = 1'b0;
        if (slot < 0) begin
            e.lat  = 1;
            e.data = '0;
        end else begin
            if (pdata >= 0) resp_data[slot] = 16'(pdata);
            resp_delay[slot] = delay;
            rogue = rogue & ~(NP'(1) << slot);
            if (delay <= TO - 1) begin
                e.lat  = delay + 2;
                e.data = resp_data[slot];
            end else begin
                e.lat     = TO + 1;
                e.data    = '1;
                timed_out = 1'b1;
            end
        end
        if (timed_out) begin
            m_et = 1'b1;
            m_ea = addr;
            m_ew = wr;
            m_ec = (clr_at == TO) ? 1 : ((m_ec == 255) ? 255 : m_ec + 1);
        end else if (clr_at >= 0 && clr_at < e.lat) begin
            m_et = 1'b0;
            m_ec = 0;
        end
        e.et = m_et;
        e.ea = m_ea;
        e.ew = m_ew;
        e.ec = 8'(m_ec);

        @(posedge clk);
        #1;
        e.start = cyc;
        sb.push_back(e);
        bus.data_m_access = 1'b1;
        bus.data_m_addr   = addr;
        bus.data_m_wr_en  = wr;
        rogue_mask        = rogue;
        err_clr           = (clr_at == 0);
        got = 1'b0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(posedge clk);
            #1;
            err_clr = (n == clr_at);
            if (bus.data_m_ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_wait: got no ack in 200 cycles, expected ack after %0d", e.lat);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        bus.data_m_access = 1'b0;
        rogue_mask        = '0;
        err_clr           = 1'b0;
    endtask

    function automatic logic [14:0] rand_addr();
        logic [15:0] full;
        int j;
        if ($urandom_range(0, 3) == 0) return 15'($urandom);
        j = $urandom_range(0, NP - 1);
        full = (BASE_P[j*AW +: AW] & MASK_P[j*AW +: AW]) | (16'($urandom) & ~MASK_P[j*AW +: AW]);
        return full[15:1];
    endfunction

    function automatic int rand_delay();
        case ($urandom_range(0, 8))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 7;
            5: return TO - 2;
            6: return TO - 1;
            7: return TO;
            default: return NEVER;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [14:0] a;
        bus.data_m_access = 1'b0;
        bus.data_m_addr   = '0;
        bus.data_m_wr_en  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", cs, '0);
        check("rst_ack", bus.data_m_ack, 1'b0);
        check("rst_data", bus.data_m_data_in, '0);
        check("rst_err_timeout", err_timeout, 1'b0);
        check("rst_err_count", err_count, '0);
        check("rst_err_addr", err_addr, '0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Slot 2 read, ack one cycle after select.
        run_txn(15'h7ffd, 1'b0, 1, '0, -1, 16'h1234);
        // Unmapped port.
        run_txn(15'h0040, 1'b0, 0, '0, -1, -1);
        // Slots 1 and 5 overlap on 0xfff0; slot 5 acks out of turn.
        run_txn(15'h7ff8, 1'b0, 2, 8'b0010_0000, -1, 16'hbeef);
        // Hung slot: timeout, err_count=1.
        run_txn(15'h1000, 1'b1, NEVER, '0, -1, -1);
        // Ack in the timeout cycle wins.
        run_txn(15'h7ffd, 1'b0, TO - 1, '0, -1, 16'h5a5a);
        // Second timeout, then timeout coinciding with err_clr.
        run_txn(15'h2000, 1'b0, NEVER, '0, -1, -1);
        run_txn(15'h1800, 1'b1, NEVER, '0, TO, -1);

        // Host abort in BUSY: select drops, no ack, no error.
        cs_free = 1'b1;
        for (int i = 0; i < NP; i++) resp_delay[i] = NEVER;
        @(posedge clk);
        #1;
        bus.data_m_access = 1'b1;
        bus.data_m_addr   = 15'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("abort_cs_busy", cs, 8'b0000_1000);
        bus.data_m_access = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs_drop", cs, '0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", bus.data_m_ack, 1'b0);
        end
        check("abort_err_count", err_count, 8'(m_ec));
        cs_free = 1'b0;

        // Asynchronous reset while BUSY.
        cs_free = 1'b1;
        @(posedge clk);
        #1;
        bus.data_m_access = 1'b1;
        bus.data_m_addr   = 15'h1802;
        repeat (4) @(posedge clk);
        #1;
        check("rstb_cs_busy", cs, 8'b0001_0000);
        #2;
        reset = 1'b1;
        #1;
        check("rstb_cs", cs, '0);
        check("rstb_ack", bus.data_m_ack, 1'b0);
        check("rstb_err_timeout", err_timeout, 1'b0);
        check("rstb_err_count", err_count, '0);
        check("rstb_err_addr", err_addr, '0);
        m_et = 1'b0;
        m_ea = '0;
        m_ew = 1'b0;
        m_ec = 0;
        bus.data_m_access = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("rstb_no_ack", bus.data_m_ack, 1'b0);
        end
        cs_free = 1'b0;
        run_txn(15'h1802, 1'b0, 3, '0, -1, -1);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            run_txn(rand_addr(), 1'($urandom), rand_delay(), NP'($urandom), -1, -1);
        end

        // err_clr while idle.
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_et = 1'b0;
        m_ec = 0;
        check("idle_clr_timeout", err_timeout, 1'b0);
        check("idle_clr_count", err_count, '0);

        // 300 timeouts saturate the counter.
        for (int t = 0; t < 300; t++) begin
            a = 15'h2000 + 15'($urandom_range(0, 2047));
            run_txn(a, 1'($urandom), NEVER, '0, -1, -1);
        end
        check("sat_err_count", err_count, 8'hff);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
